// File: rtl/uart_tx_cfg.sv
// UART transmitter with configurable data bits, parity and stop bits, fed by a
// small input FIFO so that queued words leave back-to-back on the TXD line.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 1085,
  parameter int CNT_W        = 11,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  input  logic [DATA_BITS-1:0]          i_data,
  output logic                          o_ready,
  output logic                          o_tx_serial,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]     r_level;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_bit_end;
  logic [DATA_BITS-1:0] w_head;

  assign o_ready     = (r_level != LVL_FULL);
  assign w_empty     = (r_level == '0);
  assign w_push      = i_valid && o_ready;
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_bit_end   = (r_cnt == CNT_LAST);

  assign o_tx_serial = r_tx;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_level     = r_level;

  // FIFO storage: the word is captured at the handshake, so later i_data changes are harmless
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: ;
      endcase
    end
  end

  // Line is driven from the state of the previous cycle, so every bit lags its state by one clk
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_cnt  <= w_bit_end ? '0 : r_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          r_tx      <= 1'b1;
          r_cnt     <= '0;
          r_bit_idx <= '0;
          if (!w_empty) begin
            r_shreg <= w_head;
            r_par   <= (PARITY == 1) ? ~^w_head : ^w_head;
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          r_tx <= 1'b0;
          if (w_bit_end) begin
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          r_tx <= r_shreg[0];
          if (w_bit_end) begin
            r_shreg <= r_shreg >> 1;
            if (r_bit_idx == DATA_LAST) begin
              r_bit_idx <= '0;
              r_state   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          r_tx <= r_par;
          if (w_bit_end) begin
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          r_tx <= 1'b1;
          // bit index doubles as the stop-bit counter
          if (w_bit_end) begin
            if (r_bit_idx == STOP_LAST) begin
              r_bit_idx <= '0;
              r_state   <= S_IDLE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Randomized bench for uart_tx_cfg: five frame formats side by side, each frame
// compared clock-by-clock against a waveform built from the frame rules.
module tb_uart_tx_cfg;

  localparam int NCFG = 5;
  // configs: 0=8N1, 1=8E1, 2=8O1, 3=7E2 (all 4 clks/bit), 4=9N1 at 2 clks/bit
  localparam logic [4:0][3:0] DB = {4'd9, 4'd7, 4'd8, 4'd8, 4'd8};
  localparam logic [4:0][1:0] PR = {2'd0, 2'd2, 2'd1, 2'd2, 2'd0};
  localparam logic [4:0][1:0] ST = {2'd1, 2'd2, 2'd1, 2'd1, 2'd1};
  localparam logic [4:0][3:0] CP = {4'd2, 4'd4, 4'd4, 4'd4, 4'd4};

  logic       clk = 1'b0;
  logic       rst;
  logic       r_valid;
  logic [8:0] r_data;
  int         r_sel;

  logic       w_line  [NCFG];
  logic       w_ready [NCFG];
  logic       w_busy  [NCFG];
  logic       w_done  [NCFG];
  logic [2:0] w_level [NCFG];

  logic       m_line, m_ready, m_busy, m_done;
  logic [2:0] m_level;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [8:0] q_exp[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NCFG; g++) begin : gen_dut
    uart_tx_cfg #(
      .CLKS_PER_BIT(int'(CP[g])),
      .CNT_W       (4),
      .DATA_BITS   (int'(DB[g])),
      .PARITY      (int'(PR[g])),
      .STOP_BITS   (int'(ST[g])),
      .FIFO_DEPTH  (4)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .i_valid    (r_valid && (r_sel == g)),
      .i_data     (r_data[int'(DB[g])-1:0]),
      .o_ready    (w_ready[g]),
      .o_tx_serial(w_line[g]),
      .o_busy     (w_busy[g]),
      .o_done     (w_done[g]),
      .o_level    (w_level[g])
    );
  end

  always_comb begin
    m_line  = w_line[r_sel];
    m_ready = w_ready[r_sel];
    m_busy  = w_busy[r_sel];
    m_done  = w_done[r_sel];
    m_level = w_level[r_sel];
  end

  function automatic int frame_len(input int g);
    return int'(CP[g]) * (1 + int'(DB[g]) + ((PR[g] != 0) ? 1 : 0) + int'(ST[g]));
  endfunction

  // Reference frame: start 0, data LSB first, optional parity, stop 1s, each bit CP clks
  function automatic logic [63:0] exp_wave(input int g, input logic [8:0] w);
    logic [15:0] bits;
    int          nb;
    int          ones;
    bits = '0;
    nb   = 1;
    ones = 0;
    for (int i = 0; i < int'(DB[g]); i++) begin
      bits[nb] = w[i];
      ones += int'(w[i]);
      nb++;
    end
    if (PR[g] == 2) begin
      bits[nb] = (ones % 2 == 1);
      nb++;
    end else if (PR[g] == 1) begin
      bits[nb] = (ones % 2 == 0);
      nb++;
    end
    for (int i = 0; i < int'(ST[g]); i++) begin
      bits[nb] = 1'b1;
      nb++;
    end
    exp_wave = '0;
    for (int i = 0; i < nb * int'(CP[g]); i++) begin
      exp_wave[i] = bits[i / int'(CP[g])];
    end
  endfunction

  // Called at a negedge; leaves i_valid high so the caller can stream words
  task automatic push_word(input logic [8:0] w, output bit ok);
    r_data  = w;
    r_valid = 1'b1;
    ok      = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      ok = m_ready;
      @(negedge clk);
    end
    if (ok) q_exp.push_back(w);
  endtask

  task automatic capture(output logic [63:0] wave, output logic [63:0] dmask,
                         output logic mid_busy, output int t0, output bit to);
    int len;
    len      = frame_len(r_sel);
    wave     = '0;
    dmask    = '0;
    mid_busy = 1'b0;
    t0       = 0;
    to       = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if (m_line === 1'b0) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    if (!to) begin
      t0 = cyc;
      for (int i = 0; i < len; i++) begin
        wave[i]  = m_line;
        dmask[i] = m_done;
        if (i == len / 2) mid_busy = m_busy;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    r_valid = 1'b0;
    r_data  = '0;
    r_sel   = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < NCFG; g++) begin
      n_checks++;
      if (w_line[g] !== 1'b1 || w_busy[g] !== 1'b0 || w_done[g] !== 1'b0 ||
          w_ready[g] !== 1'b1 || w_level[g] !== 3'd0) begin
        n_errors++;
        $display("FAIL reset cfg%0d: line=%b busy=%b done=%b ready=%b level=%0d, required 1 0 0 1 0",
                 g, w_line[g], w_busy[g], w_done[g], w_ready[g], w_level[g]);
      end
    end
  endtask

  task automatic test_frame_format();
    logic [8:0]  w;
    logic [8:0]  e;
    logic [63:0] wave, dmask, ew;
    logic        mid_busy;
    int          t0, len;
    bit          ok, to;
    for (int g = 0; g < NCFG; g++) begin
      r_sel = g;
      len   = frame_len(g);
      q_exp.delete();
      for (int k = 0; k < 4; k++) begin
        if (k == 0) w = (g == 3) ? 9'h07F : ((g == 4) ? 9'h1FF : 9'h0A5);
        else        w = 9'($urandom_range(0, 511));
        push_word(w, ok);
        r_valid = 1'b0;
        n_checks++;
        if (!ok) begin
          n_errors++;
          $display("FAIL push cfg%0d: ready never seen, required a push", g);
        end
        capture(wave, dmask, mid_busy, t0, to);
        e  = (q_exp.size() > 0) ? q_exp.pop_front() : 9'h000;
        ew = exp_wave(g, e);
        n_checks++;
        if (to || wave !== ew) begin
          n_errors++;
          $display("FAIL frame cfg%0d word %h: line=%h timeout=%0b, required %h", g, e, wave, to, ew);
        end
        n_checks++;
        if (dmask !== (64'd1 << (len - 1))) begin
          n_errors++;
          $display("FAIL done_timing cfg%0d: done mask=%h, required %h", g, dmask, 64'd1 << (len - 1));
        end
        n_checks++;
        if (mid_busy !== 1'b1 || m_busy !== 1'b0 || m_done !== 1'b0 || m_level !== 3'd0) begin
          n_errors++;
          $display("FAIL busy cfg%0d: mid=%b after=%b done=%b level=%0d, required 1 0 0 0",
                   g, mid_busy, m_busy, m_done, m_level);
        end
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [8:0]  words[6];
    logic [63:0] wave, dmask;
    logic [8:0]  e;
    logic        mid_busy;
    int          t0, prev_t0, len;
    bit          ok, to;
    r_sel = 0;
    len   = frame_len(0);
    q_exp.delete();
    for (int i = 0; i < 6; i++) words[i] = 9'($urandom_range(0, 255));
    prev_t0 = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          push_word(words[i], ok);
          n_checks++;
          if (!ok) begin
            n_errors++;
            $display("FAIL fifo_push %0d: ready never seen, required a push", i);
          end
          if (i == 4) begin
            n_checks++;
            if (m_level !== 3'd4 || m_ready !== 1'b0) begin
              n_errors++;
              $display("FAIL fifo_full: level=%0d ready=%b, required 4 0", m_level, m_ready);
            end
          end
        end
        r_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 6; k++) begin
          capture(wave, dmask, mid_busy, t0, to);
          e = (q_exp.size() > 0) ? q_exp.pop_front() : 9'h000;
          n_checks++;
          if (to || e !== words[k] || wave !== exp_wave(0, words[k])) begin
            n_errors++;
            $display("FAIL fifo_order frame %0d: line=%h queued=%h timeout=%0b, required word %h line %h",
                     k, wave, e, to, words[k], exp_wave(0, words[k]));
          end
          if (k > 0) begin
            n_checks++;
            if (t0 - prev_t0 !== len + 1) begin
              n_errors++;
              $display("FAIL fifo_gap frame %0d: period=%0d, required %0d", k, t0 - prev_t0, len + 1);
            end
          end
          prev_t0 = t0;
        end
      end
    join
    n_checks++;
    if (q_exp.size() != 0 || m_level !== 3'd0) begin
      n_errors++;
      $display("FAIL fifo_drain: pending=%0d level=%0d, required 0 0", q_exp.size(), m_level);
    end
  endtask

  task automatic test_push_pop();
    logic [8:0]  w3;
    logic [63:0] wave, dmask;
    logic [8:0]  e;
    logic        mid_busy;
    int          t0;
    bit          ok, to, found;
    r_sel = 0;
    q_exp.delete();
    for (int i = 0; i < 3; i++) begin
      push_word(9'($urandom_range(0, 255)), ok);
      n_checks++;
      if (!ok) begin
        n_errors++;
        $display("FAIL pp_push %0d: ready never seen, required a push", i);
      end
    end
    r_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (m_done === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!found || m_level !== 3'd2 || m_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL pp_setup: done_seen=%0b level=%0d ready=%b, required 1 2 1", found, m_level, m_ready);
    end
    if (q_exp.size() > 0) void'(q_exp.pop_front());
    w3      = 9'($urandom_range(0, 255));
    r_data  = w3;
    r_valid = 1'b1;
    @(negedge clk);
    r_valid = 1'b0;
    q_exp.push_back(w3);
    n_checks++;
    if (m_level !== 3'd2) begin
      n_errors++;
      $display("FAIL pp_level: level=%0d, required 2", m_level);
    end
    for (int k = 0; k < 3; k++) begin
      capture(wave, dmask, mid_busy, t0, to);
      e = (q_exp.size() > 0) ? q_exp.pop_front() : 9'h000;
      n_checks++;
      if (to || wave !== exp_wave(0, e)) begin
        n_errors++;
        $display("FAIL pp_order frame %0d: line=%h timeout=%0b, required %h", k, wave, to, exp_wave(0, e));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] wave, dmask;
    logic [8:0]  e;
    logic        mid_busy;
    int          t0, n_done, n_low;
    bit          ok, to;
    r_sel = 0;
    q_exp.delete();
    for (int i = 0; i < 4; i++) push_word(9'($urandom_range(0, 255)), ok);
    r_valid = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (m_busy !== 1'b1 || m_level !== 3'd3) begin
      n_errors++;
      $display("FAIL rstmid_setup: busy=%b level=%0d, required 1 3", m_busy, m_level);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q_exp.delete();
    n_checks++;
    if (m_line !== 1'b1 || m_busy !== 1'b0 || m_level !== 3'd0 || m_done !== 1'b0) begin
      n_errors++;
      $display("FAIL rstmid_abort: line=%b busy=%b level=%0d done=%b, required 1 0 0 0",
               m_line, m_busy, m_level, m_done);
    end
    n_done = 0;
    n_low  = 0;
    repeat (60) begin
      n_done += int'(m_done === 1'b1);
      n_low  += int'(m_line !== 1'b1);
      @(negedge clk);
    end
    n_checks++;
    if (n_done != 0 || n_low != 0) begin
      n_errors++;
      $display("FAIL rstmid_quiet: done pulses=%0d non-idle clks=%0d, required 0 0", n_done, n_low);
    end
    push_word(9'($urandom_range(0, 255)), ok);
    r_valid = 1'b0;
    capture(wave, dmask, mid_busy, t0, to);
    e = (q_exp.size() > 0) ? q_exp.pop_front() : 9'h000;
    n_checks++;
    if (!ok || to || wave !== exp_wave(0, e) || dmask !== (64'd1 << (frame_len(0) - 1))) begin
      n_errors++;
      $display("FAIL rstmid_resume: line=%h done=%h timeout=%0b, required %h %h",
               wave, dmask, to, exp_wave(0, e), 64'd1 << (frame_len(0) - 1));
    end
  endtask

  initial begin
    test_reset();
    test_frame_format();
    test_fifo_full();
    test_push_pop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
